exu_wb_buf: RTL and testbench
=============================

Name: exu_wb_buf

Overview:
- Writeback stage directly downstream of the execute unit.
- Captures each cycle's GPR and CSR write requests into an in-order FIFO, then drains them to the regfile and CSR write ports.
- Absorbs cycles where the regfile write port is taken by the higher-priority JTAG debug write. When full, it back-pressures execute through a hold flag to ctrl.
- Optional forwarding lookup so decode can read pending results.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
reg_we_i  in  1  GPR write request from execute
reg_waddr_i  in  `REG_ADDR_WIDTH  GPR index
reg_wdata_i  in  `REG_DATA_WIDTH  GPR data
csr_we_i  in  1  CSR write request from execute
csr_waddr_i  in  `BUS_ADDR_WIDTH  CSR address
csr_wdata_i  in  `REG_DATA_WIDTH  CSR data
jtag_reg_we_i  in  1  debug regfile write; owns the regfile port this cycle
hold_flag_o  out  1  to ctrl: buffer full, execute must hold and re-present
reg_we_o  out  1  regfile write enable
reg_waddr_o  out  `REG_ADDR_WIDTH  regfile write index
reg_wdata_o  out  `REG_DATA_WIDTH  regfile write data
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  `BUS_ADDR_WIDTH  CSR write address
csr_wdata_o  out  `REG_DATA_WIDTH  CSR write data
rs1_raddr_i  in  `REG_ADDR_WIDTH  forwarding lookup 1 (only with WB_FWD_EN)
rs2_raddr_i  in  `REG_ADDR_WIDTH  forwarding lookup 2 (only with WB_FWD_EN)
rs1_fwd_hit_o  out  1  pending write to rs1 exists
rs1_fwd_data_o  out  `REG_DATA_WIDTH  youngest pending data for rs1
rs2_fwd_hit_o  out  1  pending write to rs2 exists
rs2_fwd_data_o  out  `REG_DATA_WIDTH  youngest pending data for rs2
pending_o  out  PTR_W+1  occupied entry count

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count clear to 0.
  - All entry valid bits clear.
  - All outputs are 0.
- Push condition: (reg_we_i && reg_waddr_i!=0) || csr_we_i, and count<DEPTH.
  - A GPR write to x0 is treated as no GPR write. If csr_we_i is also 0, nothing is pushed.
  - An entry stores {gwe, gaddr, gdata, cwe, caddr, cdata}.
- Full (count==DEPTH):
  - hold_flag_o=1, driven combinationally from the count register.
  - Input is ignored that cycle; execute re-presents the request.
- Drain:
  - Outputs are driven combinationally from the head entry whenever count>0.
  - Head blocked iff head.gwe && jtag_reg_we_i. When blocked: reg_we_o=0, csr_we_o=0, no pop.
  - When not blocked: reg_we_o=head.gwe, csr_we_o=head.cwe, pop at the clock edge. A combined entry writes GPR and CSR in the same cycle.
  - A CSR-only head is never blocked by JTAG.
- Latency:
  - A request pushed at edge N is visible on the outputs in cycle N+1 at the earliest. There is no combinational input-to-output bypass.
  - Minimum latency is 1 cycle; throughput is 1 entry per cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. When full and the head is not blocked, a pop occurs but the push is refused that cycle.
- Wrap-around: pointers are PTR_W bits and wrap naturally. count is tracked separately and distinguishes full from empty.
- Ordering: strict FIFO. GPR and CSR writes retire in program order.
- Reset mid-operation: all pending entries are discarded. No partial write is emitted after rst falls.

Optional Feature:
WB_FWD_EN:
- When defined:
  - Each lookup scans all valid entries with gwe && gaddr==rsX_raddr_i && rsX_raddr_i!=0.
  - The youngest match (closest to wr_ptr) wins.
  - hit=1 with that entry's data. The current-cycle input is not included.
- When not defined:
  - rsX_fwd_hit_o=0 and rsX_fwd_data_o=0.
  - rs*_raddr_i are unused and no comparators are synthesized.

Decomposition:
- defines.v gains `WB_BUF_DEPTH (4) and the WB_FWD_EN switch comment. Entry field widths reuse existing `REG_ADDR_WIDTH, `REG_DATA_WIDTH and `BUS_ADDR_WIDTH.
- Natural sub-module: wb_fwd_match.
  - Parameterised youngest-match priority selector over DEPTH entries.
  - Instantiated twice (rs1, rs2) only under WB_FWD_EN.

Test Plan:
- Reset then a single push {x5, 0xDEADBEEF}: reg_we_o=1, waddr=5, wdata=0xDEADBEEF one cycle later. pending_o returns to 0 the following cycle.
- Push of x0 with csr_we_i=0: no entry, pending_o stays 0, reg_we_o stays 0.
- Hold jtag_reg_we_i=1 and push 5 GPR writes: after 4 entries hold_flag_o=1 and the 5th is ignored. Release jtag: drains x1..x4 in order over 4 cycles, and hold_flag_o drops after the first pop.
- CSR-only entry 0x300 <= 0x88 with jtag_reg_we_i=1: csr_we_o=1 the next cycle, not blocked. A following GPR entry waits until jtag_reg_we_i drops.
- WB_FWD_EN, pending x7=0x11 then x7=0x22 (blocked by jtag), rs1_raddr_i=7: rs1_fwd_hit_o=1, data=0x22. rs2_raddr_i=0: hit=0.
- Three entries pending, rst pulsed for half a cycle: all outputs go to 0 immediately, pending_o=0. No write appears after rst deasserts.

Source files
------------

// File: rtl/exu_wb_buf_pkg.sv
// Shared widths and the writeback-buffer entry type. The core's defines supply the widths;
// the fallbacks below only apply when built standalone. Define WB_FWD_EN to enable forwarding.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif
`ifndef WB_BUF_DEPTH
`define WB_BUF_DEPTH 4
`endif

package exu_wb_buf_pkg;

    localparam int REG_ADDR_W = `REG_ADDR_WIDTH;
    localparam int REG_DATA_W = `REG_DATA_WIDTH;
    localparam int BUS_ADDR_W = `BUS_ADDR_WIDTH;

    typedef struct packed {
        logic                  gwe;
        logic [REG_ADDR_W-1:0] gaddr;
        logic [REG_DATA_W-1:0] gdata;
        logic                  cwe;
        logic [BUS_ADDR_W-1:0] caddr;
        logic [REG_DATA_W-1:0] cdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match selector over the writeback buffer entries, used for decode forwarding.
// Only present in builds with WB_FWD_EN defined.
`ifdef WB_FWD_EN
module wb_fwd_match
    import exu_wb_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0]             gwe,
    input  logic [DEPTH-1:0][ADDR_W-1:0] gaddr,
    input  logic [DEPTH-1:0][DATA_W-1:0] gdata,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [ADDR_W-1:0]            raddr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valid[idx] && gwe[idx] && (gaddr[idx] == raddr) && (raddr != '0)) begin
                hit  = 1'b1;
                data = gdata[idx];
            end
        end
    end

endmodule
`endif

// File: rtl/exu_wb_buf.sv
// In-order writeback FIFO between execute and the regfile/CSR write ports.
// Optional decode forwarding lookup is built when WB_FWD_EN is defined.
module exu_wb_buf
    import exu_wb_buf_pkg::*;
#(
    parameter int DEPTH = `WB_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reg_we_i,
    input  logic [`REG_ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [`REG_DATA_WIDTH-1:0] reg_wdata_i,
    input  logic                       csr_we_i,
    input  logic [`BUS_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [`REG_DATA_WIDTH-1:0] csr_wdata_i,
    input  logic                       jtag_reg_we_i,
    output logic                       hold_flag_o,
    output logic                       reg_we_o,
    output logic [`REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [`REG_DATA_WIDTH-1:0] reg_wdata_o,
    output logic                       csr_we_o,
    output logic [`BUS_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [`REG_DATA_WIDTH-1:0] csr_wdata_o,
    input  logic [`REG_ADDR_WIDTH-1:0] rs1_raddr_i,
    input  logic [`REG_ADDR_WIDTH-1:0] rs2_raddr_i,
    output logic                       rs1_fwd_hit_o,
    output logic [`REG_DATA_WIDTH-1:0] rs1_fwd_data_o,
    output logic                       rs2_fwd_hit_o,
    output logic [`REG_DATA_WIDTH-1:0] rs2_fwd_data_o,
    output logic [PTR_W:0]             pending_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    wb_entry_t        entry_in;
    wb_entry_t        head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             blocked;

    // A write to x0 is dropped here; unused fields are zeroed so the head never shows stale input.
    always_comb begin
        entry_in     = '0;
        entry_in.gwe = reg_we_i && (reg_waddr_i != '0);
        entry_in.cwe = csr_we_i;
        if (entry_in.gwe) begin
            entry_in.gaddr = reg_waddr_i;
            entry_in.gdata = reg_wdata_i;
        end
        if (entry_in.cwe) begin
            entry_in.caddr = csr_waddr_i;
            entry_in.cdata = csr_wdata_i;
        end
    end

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = (entry_in.gwe || entry_in.cwe) && !full;
    assign head    = mem[rd_ptr];
    assign blocked = head.gwe && jtag_reg_we_i;
    assign pop     = !empty && !blocked;

    assign hold_flag_o = full;
    assign pending_o   = count;

    always_comb begin
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        if (!empty) begin
            reg_we_o    = head.gwe && !blocked;
            reg_waddr_o = head.gaddr;
            reg_wdata_o = head.gdata;
            csr_we_o    = head.cwe && !blocked;
            csr_waddr_o = head.caddr;
            csr_wdata_o = head.cdata;
        end
    end

    // NOTE: entry payload has no reset; valid bits and count alone decide what is pending.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every update based on pre-edge state.
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FWD_EN
    logic [DEPTH-1:0]                      ent_gwe;
    logic [DEPTH-1:0][`REG_ADDR_WIDTH-1:0] ent_gaddr;
    logic [DEPTH-1:0][`REG_DATA_WIDTH-1:0] ent_gdata;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_gwe[i]   = mem[i].gwe;
        assign ent_gaddr[i] = mem[i].gaddr;
        assign ent_gdata[i] = mem[i].gdata;
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (`REG_ADDR_WIDTH),
        .DATA_W (`REG_DATA_WIDTH)
    ) u_rs1_match (
        .valid  (valid),
        .gwe    (ent_gwe),
        .gaddr  (ent_gaddr),
        .gdata  (ent_gdata),
        .rd_ptr (rd_ptr),
        .raddr  (rs1_raddr_i),
        .hit    (rs1_fwd_hit_o),
        .data   (rs1_fwd_data_o)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (`REG_ADDR_WIDTH),
        .DATA_W (`REG_DATA_WIDTH)
    ) u_rs2_match (
        .valid  (valid),
        .gwe    (ent_gwe),
        .gaddr  (ent_gaddr),
        .gdata  (ent_gdata),
        .rd_ptr (rd_ptr),
        .raddr  (rs2_raddr_i),
        .hit    (rs2_fwd_hit_o),
        .data   (rs2_fwd_data_o)
    );
`else
    logic unused_fwd;
    assign unused_fwd     = ^{rs1_raddr_i, rs2_raddr_i, valid};
    assign rs1_fwd_hit_o  = 1'b0;
    assign rs1_fwd_data_o = '0;
    assign rs2_fwd_hit_o  = 1'b0;
    assign rs2_fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_exu_wb_buf.sv
// Directed bench for exu_wb_buf: push/drain, x0 drop, full hold, JTAG blocking, forwarding, reset.
module tb_exu_wb_buf;
    import exu_wb_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
`ifdef WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  reg_we_i;
    logic [REG_ADDR_W-1:0] reg_waddr_i;
    logic [REG_DATA_W-1:0] reg_wdata_i;
    logic                  csr_we_i;
    logic [BUS_ADDR_W-1:0] csr_waddr_i;
    logic [REG_DATA_W-1:0] csr_wdata_i;
    logic                  jtag_reg_we_i;
    logic                  hold_flag_o;
    logic                  reg_we_o;
    logic [REG_ADDR_W-1:0] reg_waddr_o;
    logic [REG_DATA_W-1:0] reg_wdata_o;
    logic                  csr_we_o;
    logic [BUS_ADDR_W-1:0] csr_waddr_o;
    logic [REG_DATA_W-1:0] csr_wdata_o;
    logic [REG_ADDR_W-1:0] rs1_raddr_i;
    logic [REG_ADDR_W-1:0] rs2_raddr_i;
    logic                  rs1_fwd_hit_o;
    logic [REG_DATA_W-1:0] rs1_fwd_data_o;
    logic                  rs2_fwd_hit_o;
    logic [REG_DATA_W-1:0] rs2_fwd_data_o;
    logic [PTR_W:0]        pending_o;

    int total = 0;
    int bad   = 0;

    exu_wb_buf #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_we_i       (reg_we_i),
        .reg_waddr_i    (reg_waddr_i),
        .reg_wdata_i    (reg_wdata_i),
        .csr_we_i       (csr_we_i),
        .csr_waddr_i    (csr_waddr_i),
        .csr_wdata_i    (csr_wdata_i),
        .jtag_reg_we_i  (jtag_reg_we_i),
        .hold_flag_o    (hold_flag_o),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .rs1_raddr_i    (rs1_raddr_i),
        .rs2_raddr_i    (rs2_raddr_i),
        .rs1_fwd_hit_o  (rs1_fwd_hit_o),
        .rs1_fwd_data_o (rs1_fwd_data_o),
        .rs2_fwd_hit_o  (rs2_fwd_hit_o),
        .rs2_fwd_data_o (rs2_fwd_data_o),
        .pending_o      (pending_o)
    );

    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are read 1 ns later, well clear of posedge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        reg_we_i    = 1'b0;
        reg_waddr_i = '0;
        reg_wdata_i = '0;
        csr_we_i    = 1'b0;
        csr_waddr_i = '0;
        csr_wdata_i = '0;
    endtask

    task automatic drive_gpr(input logic [REG_ADDR_W-1:0] a, input logic [REG_DATA_W-1:0] d);
        idle();
        reg_we_i    = 1'b1;
        reg_waddr_i = a;
        reg_wdata_i = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        jtag_reg_we_i = 1'b0;
        rs1_raddr_i   = '0;
        rs2_raddr_i   = '0;
        repeat (2) next_cycle();
        #1;
        total++; if (pending_o !== '0) begin bad++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
        total++; if (hold_flag_o !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", hold_flag_o); end
        total++; if ({reg_we_o, csr_we_o} !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", {reg_we_o, csr_we_o}); end
        total++; if (reg_wdata_o !== '0 || csr_waddr_o !== '0) begin bad++; $display("FAIL reset_data: got %h/%h want 0/0", reg_wdata_o, csr_waddr_o); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_push();
        drive_gpr(5'd5, 32'hDEADBEEF);
        #1;
        total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", reg_we_o); end
        next_cycle(); idle(); #1;
        total++; if (reg_we_o !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", reg_we_o); end
        total++; if (reg_waddr_o !== 5'd5) begin bad++; $display("FAIL single_waddr: got %0d want 5", reg_waddr_o); end
        total++; if (reg_wdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata: got %h want deadbeef", reg_wdata_o); end
        total++; if (pending_o !== 3'd1) begin bad++; $display("FAIL single_pending1: got %0d want 1", pending_o); end
        next_cycle(); #1;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL single_pending0: got %0d want 0", pending_o); end
        total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL single_we_after: got %b want 0", reg_we_o); end
    endtask

    task automatic test_x0_drop();
        drive_gpr(5'd0, 32'h1234_5678);
        next_cycle(); idle(); #1;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL x0_pending: got %0d want 0", pending_o); end
        total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL x0_we: got %b want 0", reg_we_o); end
    endtask

    task automatic test_full_hold();
        jtag_reg_we_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_gpr(REG_ADDR_W'(i), 32'h100 + i);
            next_cycle();
        end
        drive_gpr(5'd5, 32'h105);
        #1;
        total++; if (hold_flag_o !== 1'b1) begin bad++; $display("FAIL full_hold: got %b want 1", hold_flag_o); end
        total++; if (pending_o !== 3'd4) begin bad++; $display("FAIL full_pending: got %0d want 4", pending_o); end
        total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL full_blocked_we: got %b want 0", reg_we_o); end
        next_cycle(); idle(); #1;
        total++; if (pending_o !== 3'd4) begin bad++; $display("FAIL full_fifth_ignored: got %0d want 4", pending_o); end
        jtag_reg_we_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (hold_flag_o !== (i == 1)) begin bad++; $display("FAIL drain_hold_%0d: got %b want %b", i, hold_flag_o, i == 1); end
            total++; if (reg_we_o !== 1'b1 || reg_waddr_o !== REG_ADDR_W'(i) || reg_wdata_o !== 32'h100 + i) begin
                bad++; $display("FAIL drain_%0d: got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, reg_we_o, reg_waddr_o, reg_wdata_o, i, 32'h100 + i);
            end
            next_cycle();
        end
        #1;
        total++; if (pending_o !== 3'd0 || reg_we_o !== 1'b0) begin bad++; $display("FAIL drain_done: got p=%0d we=%b want p=0 we=0", pending_o, reg_we_o); end
    endtask

    task automatic test_csr_jtag();
        jtag_reg_we_i = 1'b1;
        idle();
        csr_we_i    = 1'b1;
        csr_waddr_i = 32'h300;
        csr_wdata_i = 32'h88;
        next_cycle();
        drive_gpr(5'd9, 32'h99);
        #1;
        total++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h88) begin
            bad++; $display("FAIL csr_unblocked: got we=%b a=%h d=%h want we=1 a=300 d=88", csr_we_o, csr_waddr_o, csr_wdata_o);
        end
        total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL csr_no_gpr: got %b want 0", reg_we_o); end
        next_cycle(); idle(); #1;
        total++; if ({reg_we_o, csr_we_o} !== 2'b00 || pending_o !== 3'd1 || reg_waddr_o !== 5'd9) begin
            bad++; $display("FAIL gpr_blocked: got we=%b%b p=%0d a=%0d want we=00 p=1 a=9", reg_we_o, csr_we_o, pending_o, reg_waddr_o);
        end
        next_cycle(); #1;
        total++; if (reg_we_o !== 1'b0 || pending_o !== 3'd1) begin bad++; $display("FAIL gpr_still_blocked: got we=%b p=%0d want we=0 p=1", reg_we_o, pending_o); end
        jtag_reg_we_i = 1'b0;
        #1;
        total++; if (reg_we_o !== 1'b1 || reg_wdata_o !== 32'h99) begin bad++; $display("FAIL gpr_released: got we=%b d=%h want we=1 d=99", reg_we_o, reg_wdata_o); end
        next_cycle(); #1;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL csr_drained: got %0d want 0", pending_o); end
    endtask

    task automatic test_back_to_back();
        drive_gpr(5'd10, 32'hA0);
        next_cycle();
        drive_gpr(5'd11, 32'hA1);
        #1;
        total++; if (reg_waddr_o !== 5'd10 || reg_we_o !== 1'b1 || pending_o !== 3'd1) begin
            bad++; $display("FAIL b2b_first: got a=%0d we=%b p=%0d want a=10 we=1 p=1", reg_waddr_o, reg_we_o, pending_o);
        end
        next_cycle();
        drive_gpr(5'd3, 32'h33);
        csr_we_i    = 1'b1;
        csr_waddr_i = 32'h305;
        csr_wdata_i = 32'h55;
        #1;
        total++; if (reg_waddr_o !== 5'd11 || reg_wdata_o !== 32'hA1 || pending_o !== 3'd1) begin
            bad++; $display("FAIL b2b_second: got a=%0d d=%h p=%0d want a=11 d=a1 p=1", reg_waddr_o, reg_wdata_o, pending_o);
        end
        next_cycle(); idle(); #1;
        total++; if ({reg_we_o, csr_we_o} !== 2'b11 || reg_waddr_o !== 5'd3 || csr_waddr_o !== 32'h305 || csr_wdata_o !== 32'h55) begin
            bad++; $display("FAIL b2b_combined: got we=%b%b a=%0d ca=%h cd=%h want we=11 a=3 ca=305 cd=55", reg_we_o, csr_we_o, reg_waddr_o, csr_waddr_o, csr_wdata_o);
        end
        next_cycle(); #1;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL b2b_drained: got %0d want 0", pending_o); end
    endtask

    task automatic test_fwd();
        jtag_reg_we_i = 1'b1;
        rs1_raddr_i   = 5'd7;
        rs2_raddr_i   = 5'd0;
        drive_gpr(5'd7, 32'h11);
        #1;
        total++; if (rs1_fwd_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_no_input: got %b want 0", rs1_fwd_hit_o); end
        next_cycle();
        drive_gpr(5'd7, 32'h22);
        #1;
        total++; if (rs1_fwd_hit_o !== FWD_EN || rs1_fwd_data_o !== (FWD_EN ? 32'h11 : 32'h0)) begin
            bad++; $display("FAIL fwd_one: got hit=%b d=%h want hit=%b", rs1_fwd_hit_o, rs1_fwd_data_o, FWD_EN);
        end
        next_cycle(); idle(); #1;
        total++; if (rs1_fwd_hit_o !== FWD_EN || rs1_fwd_data_o !== (FWD_EN ? 32'h22 : 32'h0)) begin
            bad++; $display("FAIL fwd_youngest: got hit=%b d=%h want hit=%b d=%h", rs1_fwd_hit_o, rs1_fwd_data_o, FWD_EN, FWD_EN ? 32'h22 : 32'h0);
        end
        total++; if (rs2_fwd_hit_o !== 1'b0 || rs2_fwd_data_o !== '0) begin bad++; $display("FAIL fwd_x0: got hit=%b d=%h want 0", rs2_fwd_hit_o, rs2_fwd_data_o); end
        rs1_raddr_i = 5'd3;
        #1;
        total++; if (rs1_fwd_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_miss: got %b want 0", rs1_fwd_hit_o); end
        jtag_reg_we_i = 1'b0;
        repeat (2) next_cycle();
        #1;
        total++; if (pending_o !== 3'd0 || rs1_fwd_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_drained: got p=%0d hit=%b want 0", pending_o, rs1_fwd_hit_o); end
        rs1_raddr_i = '0;
    endtask

    task automatic test_reset_mid();
        jtag_reg_we_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_gpr(REG_ADDR_W'(i), 32'h200 + i);
            next_cycle();
        end
        idle();
        #1;
        total++; if (pending_o !== 3'd3) begin bad++; $display("FAIL mid_pending3: got %0d want 3", pending_o); end
        jtag_reg_we_i = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (pending_o !== '0 || reg_we_o !== 1'b0 || reg_waddr_o !== '0 || reg_wdata_o !== '0 || hold_flag_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outputs: got p=%0d we=%b a=%0d d=%h h=%b want all 0", pending_o, reg_we_o, reg_waddr_o, reg_wdata_o, hold_flag_o);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            total++; if (reg_we_o !== 1'b0 || pending_o !== '0) begin bad++; $display("FAIL mid_no_write_%0d: got we=%b p=%0d want 0/0", i, reg_we_o, pending_o); end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_x0_drop();
        test_full_hold();
        test_csr_jtag();
        test_back_to_back();
        test_fwd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
